// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-port memory between an instruction-fetch port and a
//   data port. Data accesses win conflicts. After MAX_WAIT consecutive
//   denied fetch cycles, fetch wins the next conflict. Read data returns one
//   cycle after the grant and is steered to the port that owned the access.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   if_req/if_addr     fetch request and byte address
//   if_gnt             fetch accepted this cycle
//   if_rvalid/if_rdata fetch data one cycle after if_gnt
//   d_req/d_addr       data request and byte address
//   d_wdata/d_we       store data and byte enables (d_we == 0 is a load)
//   d_gnt              data access accepted this cycle
//   d_rvalid/d_rdata   load data one cycle after a read d_gnt
//   mem_req/addr/wdata/we  memory strobe and access fields
//   mem_rdata          memory read data, valid one cycle after mem_req
//   conflict_cnt       free-running count of cycles with both requests high
module mem_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_we,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_we,
  input  logic [31:0] mem_rdata,
  output logic [31:0] conflict_cnt
);

  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

  logic [3:0]  wait_q, wait_d;
  logic        if_own_q, if_own_d;
  logic        d_own_q, d_own_d;
  logic [31:0] cnt_q, cnt_d;
  logic        fetch_due;

  always_comb begin
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    fetch_due = (wait_q == MaxWait);

    if (!rst) begin
      if (if_req && (!d_req || fetch_due)) begin
        if_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end
    end

    mem_req   = if_gnt | d_gnt;
    mem_addr  = if_gnt ? if_addr : (d_gnt ? d_addr : 32'h0);
    mem_we    = d_gnt ? d_we : 4'h0;
    mem_wdata = d_gnt ? d_wdata : 32'h0;

    // Starvation counter only tracks an unbroken run of denied fetches.
    if (!if_req || if_gnt) begin
      wait_d = 4'h0;
    end else if (wait_q != MaxWait) begin
      wait_d = wait_q + 4'h1;
    end else begin
      wait_d = wait_q;
    end

    // Writes complete in the grant cycle, so only loads own a response slot.
    if_own_d = if_gnt;
    d_own_d  = d_gnt && (d_we == 4'h0);

    cnt_d = (if_req && d_req) ? cnt_q + 32'h1 : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q   <= 4'h0;
      if_own_q <= 1'b0;
      d_own_q  <= 1'b0;
      cnt_q    <= 32'h0;
    end else begin
      wait_q   <= wait_d;
      if_own_q <= if_own_d;
      d_own_q  <= d_own_d;
      cnt_q    <= cnt_d;
    end
  end

  // Gating with rst drops a response whose grant was followed by reset.
  assign if_rvalid    = if_own_q & ~rst;
  assign d_rvalid     = d_own_q & ~rst;
  assign if_rdata     = if_rvalid ? mem_rdata : 32'h0;
  assign d_rdata      = d_rvalid ? mem_rdata : 32'h0;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Drives mem_arbiter with directed scenarios and random traffic, and
//   compares every output against a behavioural model of the arbitration
//   rules held in the bench.
module tb_mem_arbiter;

  localparam int MAX_WAIT = 4;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_we;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_we;
  logic [31:0] mem_rdata;
  logic [31:0] conflict_cnt;

  mem_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state
  int          streak;       // consecutive denied fetch cycles, capped at MAX_WAIT
  bit          pend_if;      // fetch response due next cycle
  bit          pend_d;       // load response due next cycle
  logic [31:0] exp_cnt;
  bit          exp_if, exp_d;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply one cycle of inputs and check all outputs against the model.
  task automatic drive(input bit r, input bit ir, input logic [31:0] ia,
                       input bit dr, input logic [31:0] da, input logic [31:0] dwd,
                       input logic [3:0] dwe, input logic [31:0] mrd);
    logic [31:0] e_addr;
    bit e_ifv, e_dv;
    @(negedge clk);
    rst = r; if_req = ir; if_addr = ia; d_req = dr; d_addr = da;
    d_wdata = dwd; d_we = dwe; mem_rdata = mrd;
    #1;
    exp_if = !r && ir && (!dr || streak == MAX_WAIT);
    exp_d  = !r && dr && !exp_if;
    e_addr = exp_if ? ia : (exp_d ? da : 32'h0);
    e_ifv  = pend_if && !r;
    e_dv   = pend_d && !r;
    chk("if_gnt",       32'(if_gnt), 32'(exp_if));
    chk("d_gnt",        32'(d_gnt), 32'(exp_d));
    chk("mem_req",      32'(mem_req), 32'(exp_if | exp_d));
    chk("mem_addr",     mem_addr, e_addr);
    chk("mem_we",       32'(mem_we), exp_d ? 32'(dwe) : 32'h0);
    chk("mem_wdata",    mem_wdata, exp_d ? dwd : 32'h0);
    chk("if_rvalid",    32'(if_rvalid), 32'(e_ifv));
    chk("if_rdata",     if_rdata, e_ifv ? mrd : 32'h0);
    chk("d_rvalid",     32'(d_rvalid), 32'(e_dv));
    chk("d_rdata",      d_rdata, e_dv ? mrd : 32'h0);
    chk("conflict_cnt", conflict_cnt, exp_cnt);
  endtask

  // Advance the model to the next edge using the inputs currently applied.
  task automatic tick();
    if (rst) begin
      streak = 0; pend_if = 0; pend_d = 0; exp_cnt = 32'h0;
    end else begin
      if (if_req && !exp_if) streak = (streak < MAX_WAIT) ? streak + 1 : streak;
      else streak = 0;
      pend_if = exp_if;
      pend_d  = exp_d && (d_we == 4'h0);
      if (if_req && d_req) exp_cnt = exp_cnt + 32'h1;
    end
    @(posedge clk);
  endtask

  task automatic idle(input bit r);
    drive(r, 0, 32'h0, 0, 32'h0, 32'h0, 4'h0, $urandom);
    tick();
  endtask

  initial begin
    streak = 0; pend_if = 0; pend_d = 0; exp_cnt = 32'h0;
    rst = 1; if_req = 0; if_addr = 0; d_req = 0; d_addr = 0;
    d_wdata = 0; d_we = 0; mem_rdata = 0;
    @(posedge clk);

    // Reset blocks grants even with both requests asserted
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, $urandom, 1, $urandom, $urandom, 4'hF, $urandom);
      chk("rst_no_gnt", 32'(if_gnt | d_gnt | mem_req), 32'h0);
      tick();
    end

    // First cycle out of reset: fetch only, then its data
    drive(0, 1, 32'h100, 0, 32'h0, 32'h0, 4'h0, $urandom);
    chk("fetch_gnt", 32'(if_gnt), 32'h1);
    chk("fetch_addr", mem_addr, 32'h100);
    tick();
    drive(0, 0, 32'h0, 0, 32'h0, 32'h0, 4'h0, 32'h00100073);
    chk("fetch_rvalid", 32'(if_rvalid), 32'h1);
    chk("fetch_rdata", if_rdata, 32'h00100073);
    tick();

    // Partial store: granted, no load response follows
    drive(0, 0, 32'h0, 1, 32'h2000, 32'hDEADBEEF, 4'b0011, $urandom);
    chk("store_gnt", 32'(d_gnt), 32'h1);
    chk("store_we", 32'(mem_we), 32'h3);
    chk("store_wdata", mem_wdata, 32'hDEADBEEF);
    tick();
    drive(0, 0, 32'h0, 0, 32'h0, 32'h0, 4'h0, $urandom);
    chk("store_no_rvalid", 32'(d_rvalid), 32'h0);
    tick();

    // Sustained conflict: four data grants then one fetch grant, repeating
    idle(1);
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 32'h40 + 32'(i), 1, 32'h8000 + 32'(i), 32'h0, 4'h0, $urandom);
      chk("conf_if_gnt", 32'(if_gnt), (i % 5 == 4) ? 32'h1 : 32'h0);
      chk("conf_d_gnt", 32'(d_gnt), (i % 5 == 4) ? 32'h0 : 32'h1);
      tick();
    end
    drive(0, 0, 32'h0, 0, 32'h0, 32'h0, 4'h0, $urandom);
    chk("conf_cnt10", conflict_cnt, 32'd10);
    tick();
    idle(0);

    // Alternating fetch / data-load grants on consecutive cycles
    for (int i = 0; i < 9; i++) begin
      if (i == 8) drive(0, 0, 32'h0, 0, 32'h0, 32'h0, 4'h0, $urandom);
      else if (i % 2 == 0) drive(0, 1, 32'h300 + 32'(i), 0, 32'h0, 32'h0, 4'h0, $urandom);
      else drive(0, 0, 32'h0, 1, 32'h500 + 32'(i), 32'h0, 4'h0, $urandom);
      chk("alt_if_rvalid", 32'(if_rvalid), (i > 0 && (i - 1) % 2 == 0) ? 32'h1 : 32'h0);
      chk("alt_d_rvalid", 32'(d_rvalid), (i > 0 && (i - 1) % 2 == 1) ? 32'h1 : 32'h0);
      chk("alt_not_both", 32'(if_rvalid & d_rvalid), 32'h0);
      tick();
    end

    // Reset right after a fetch grant drops the response and clears state
    drive(0, 1, 32'h0, 1, 32'h0, 32'h0, 4'h0, $urandom);
    tick();
    drive(0, 1, 32'h700, 0, 32'h0, 32'h0, 4'h0, $urandom);
    chk("pre_rst_gnt", 32'(if_gnt), 32'h1);
    tick();
    drive(1, 1, 32'h0, 1, 32'h0, 32'h0, 4'h0, $urandom);
    chk("rst_kill_rvalid", 32'(if_rvalid), 32'h0);
    tick();
    drive(0, 0, 32'h0, 0, 32'h0, 32'h0, 4'h0, $urandom);
    chk("rst_wait_cnt", 32'(dut.wait_q), 32'h0);
    chk("rst_conflict_cnt", conflict_cnt, 32'h0);
    tick();

    // Conflict counter wrap
    #2;
    dut.cnt_q = 32'hFFFF_FFFF;
    exp_cnt = 32'hFFFF_FFFF;
    drive(0, 1, 32'h0, 1, 32'h0, 32'h0, 4'h0, $urandom);
    tick();
    drive(0, 0, 32'h0, 0, 32'h0, 32'h0, 4'h0, $urandom);
    chk("cnt_wrap", conflict_cnt, 32'h0);
    tick();

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 24) == 0),
            $urandom_range(0, 1) == 1, $urandom,
            $urandom_range(0, 1) == 1, $urandom, $urandom,
            ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom),
            $urandom);
      chk("rand_not_both_gnt", 32'(if_gnt & d_gnt), 32'h0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_WAIT, default 4, meaning the number of consecutive denied instruction-fetch cycles after which fetch wins; legal range 1..15.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port if_req, input, 1, fetch request.
REQ-005 The block SHALL have port if_addr, input, 32, fetch byte address.
REQ-006 The block SHALL have port if_gnt, output, 1, fetch accepted this cycle.
REQ-007 The block SHALL have port if_rvalid, output, 1, fetch data valid.
REQ-008 The block SHALL have port if_rdata, output, 32, fetch read data.
REQ-009 The block SHALL have port d_req, input, 1, data access request.
REQ-010 The block SHALL have port d_addr, input, 32, data byte address.
REQ-011 The block SHALL have port d_wdata, input, 32, store data.
REQ-012 The block SHALL have port d_we, input, 4, byte write enables; 0 means read.
REQ-013 The block SHALL have port d_gnt, output, 1, data access accepted this cycle.
REQ-014 The block SHALL have port d_rvalid, output, 1, load data valid.
REQ-015 The block SHALL have port d_rdata, output, 32, load read data.
REQ-016 The block SHALL have port mem_req, output, 1, single-port memory access strobe.
REQ-017 The block SHALL have port mem_addr, output, 32, memory address.
REQ-018 The block SHALL have port mem_wdata, output, 32, memory write data.
REQ-019 The block SHALL have port mem_we, output, 4, memory byte write enables.
REQ-020 The block SHALL have port mem_rdata, input, 32, read data returned one cycle after mem_req.
REQ-021 The block SHALL have port conflict_cnt, output, 32, count of cycles with if_req and d_req both high.

Function
REQ-022 Arbitration SHALL be combinational within a cycle, with at most one grant per cycle.
REQ-023 Only if_req high SHALL yield if_gnt; only d_req high SHALL yield d_gnt.
REQ-024 With both requests high, d_gnt SHALL be asserted unless wait_cnt == MAX_WAIT, in which case if_gnt SHALL be asserted.
REQ-025 wait_cnt (4 bit) SHALL increment when if_req && !if_gnt, saturate at MAX_WAIT, and clear to 0 on if_gnt or when if_req is low.
REQ-026 mem_req SHALL equal if_gnt | d_gnt.
REQ-027 mem_addr SHALL be the granted requester's address, or 0 when idle.
REQ-028 mem_we SHALL equal d_we on d_gnt, else 0.
REQ-029 mem_wdata SHALL equal d_wdata on d_gnt, else 0.
REQ-030 A fetch grant SHALL register a response owner; if_rvalid SHALL be 1 in the following cycle and if_rdata SHALL equal mem_rdata in that cycle.
REQ-031 A data grant with d_we == 0 SHALL produce d_rvalid = 1 one cycle later, with d_rdata = mem_rdata.
REQ-032 A data grant with d_we != 0 SHALL produce no d_rvalid; the write completes in the grant cycle.
REQ-033 if_rdata SHALL be 0 whenever if_rvalid is 0, and d_rdata SHALL be 0 whenever d_rvalid is 0.
REQ-034 Back-to-back grants on consecutive cycles SHALL be supported, so throughput is one access per cycle.
REQ-035 if_rvalid and d_rvalid SHALL never be high in the same cycle.
REQ-036 A requester SHALL hold req, address, data and we stable until its grant; the arbiter does not latch requests.
REQ-037 conflict_cnt SHALL increment by 1 on every cycle with if_req && d_req and wrap from 0xFFFFFFFF to 0.
REQ-038 Addresses SHALL pass through unmodified, with no alignment checking.

Reset
REQ-039 While rst is high, if_gnt, d_gnt, mem_req and mem_we SHALL be 0 regardless of requests.
REQ-040 On a clock edge with rst high, wait_cnt, the response-owner registers and conflict_cnt SHALL clear to 0.
REQ-041 If rst is asserted in the cycle after a grant, the pending rvalid SHALL be suppressed (rvalid = 0).
REQ-042 The first grant SHALL be possible in the first cycle with rst low.

Verification
REQ-043 The bench SHALL check: if_req only, if_addr=0x100, mem_rdata=0x00100073 next cycle -> if_gnt=1, mem_addr=0x100, then if_rvalid=1, if_rdata=0x00100073.
REQ-044 The bench SHALL check: d_req with d_we=4'b0011, d_addr=0x2000, d_wdata=0xDEADBEEF -> d_gnt=1, mem_we=0011, mem_wdata=0xDEADBEEF, and no d_rvalid next cycle.
REQ-045 The bench SHALL check: if_req and d_req held high continuously (data reads), MAX_WAIT=4 -> d_gnt for 4 cycles, if_gnt on cycle 5, then the pattern repeats; conflict_cnt=10 after 10 cycles.
REQ-046 The bench SHALL check: alternating fetch and data grants on consecutive cycles -> each rvalid lands one cycle after its grant on the correct port, and never both in one cycle.
REQ-047 The bench SHALL check: rst asserted the cycle after a fetch grant -> if_rvalid=0, and wait_cnt=0 and conflict_cnt=0 after the edge.
REQ-048 The bench SHALL check: conflict_cnt forced to 0xFFFFFFFF, then one conflict cycle -> conflict_cnt=0.
